// File: rtl/cp0_mmu_if.sv
// cp0_mmu_if: pipeline-to-CP0 bus (WB commit info, mtc0/mfc0 access, TLB strobes and read port, CP0 state outputs)
interface cp0_mmu_if #(
  parameter int TLBNUM = 16
) ();
  localparam int IDXW = $clog2(TLBNUM);
  logic            wb_ex;
  logic            wb_bd;
  logic            wb_eret;
  logic [4:0]      wb_excode;
  logic [31:0]     wb_pc;
  logic [31:0]     wb_badvaddr;
  logic [5:0]      ext_int_in;
  logic [7:0]      cp0_addr;
  logic            mtc0_we;
  logic [31:0]     cp0_wdata;
  logic [31:0]     cp0_rdata;
  logic            tlbp;
  logic            tlbr;
  logic            tlbwi;
  logic            tlbwr;
  logic            s1_found;
  logic [IDXW-1:0] s1_index;
  logic [18:0]     r_vpn2;
  logic [7:0]      r_asid;
  logic            r_g;
  logic [19:0]     r_pfn0;
  logic [2:0]      r_c0;
  logic            r_d0;
  logic            r_v0;
  logic [19:0]     r_pfn1;
  logic [2:0]      r_c1;
  logic            r_d1;
  logic            r_v1;
  logic [IDXW-1:0] w_index;
  logic [31:0]     cp0_entryhi;
  logic [31:0]     cp0_entrylo0;
  logic [31:0]     cp0_entrylo1;
  logic [31:0]     cp0_epc;
  logic [31:0]     cp0_status;
  logic [31:0]     cp0_cause;
  logic            int_req;
  modport master (
    output wb_ex, wb_bd, wb_eret, wb_excode, wb_pc, wb_badvaddr, ext_int_in,
           cp0_addr, mtc0_we, cp0_wdata, tlbp, tlbr, tlbwi, tlbwr, s1_found, s1_index,
           r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    input  cp0_rdata, w_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_epc,
           cp0_status, cp0_cause, int_req
  );
  modport slave (
    input  wb_ex, wb_bd, wb_eret, wb_excode, wb_pc, wb_badvaddr, ext_int_in,
           cp0_addr, mtc0_we, cp0_wdata, tlbp, tlbr, tlbwi, tlbwr, s1_found, s1_index,
           r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    output cp0_rdata, w_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_epc,
           cp0_status, cp0_cause, int_req
  );
endinterface

// File: rtl/cp0_mmu.sv
// cp0_mmu: MIPS CP0 registers with TLB management state, timer and interrupt request.
// Define CP0_CONTEXT_EN to implement the Context register; otherwise it reads 0.
module cp0_mmu #(
  parameter int TLBNUM    = 16,
  parameter int COUNT_DIV = 2
) (
  input logic      clk,
  input logic      resetn,
  cp0_mmu_if.slave bus
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [IDXW-1:0] RMAX = IDXW'(TLBNUM - 1);
  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);
  localparam logic [7:0] A_INDEX = 8'h00, A_RANDOM = 8'h08, A_LO0 = 8'h10, A_LO1 = 8'h18,
                         A_CONTEXT = 8'h20, A_WIRED = 8'h30, A_BADV = 8'h40, A_COUNT = 8'h48,
                         A_EHI = 8'h50, A_COMPARE = 8'h58, A_STATUS = 8'h60, A_CAUSE = 8'h68,
                         A_EPC = 8'h70;
  logic            idx_p;
  logic [IDXW-1:0] idx, random, wired;
  logic [31:0]     count, compare, epc, badvaddr;
  logic [3:0]      div;
  logic [18:0]     vpn2;
  logic [7:0]      asid;
  logic [25:0]     lo0, lo1;
  logic            bev, exl, ie, bd, ti;
  logic [7:0]      im, ip;
  logic [5:0]      ip_hw;
  logic [1:0]      ip_sw;
  logic [4:0]      exccode;
  logic [7:0]      wa;
  logic            tlb_ex, addr_ex;
  logic [31:0]     index_r, entryhi_r, status_r, cause_r, context_r;
  logic            unused;
  assign unused  = bus.tlbwi;
  assign wa      = bus.mtc0_we ? bus.cp0_addr : 8'hff;
  assign tlb_ex  = bus.wb_ex && bus.wb_excode inside {5'd1, 5'd2, 5'd3};
  assign addr_ex = bus.wb_ex && bus.wb_excode inside {5'd4, 5'd5};
  always_ff @(posedge clk)
    if (!resetn) begin
      idx_p   <= 1'b0;
      idx     <= '0;
      random  <= RMAX;
      wired   <= '0;
      count   <= '0;
      div     <= '0;
      bev     <= 1'b1;
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      ti      <= 1'b0;
      ip_hw   <= '0;
      ip_sw   <= '0;
      exccode <= '0;
    end else begin
      if (bus.tlbp) begin
        idx_p <= ~bus.s1_found;
        if (bus.s1_found) idx <= bus.s1_index;
      end else if (wa == A_INDEX) idx <= bus.cp0_wdata[IDXW-1:0];
      // Reloading on Random==Wired keeps Random inside [Wired, TLBNUM-1]
      random <= (wa == A_WIRED || random == wired) ? RMAX : random - 1'b1;
      if (wa == A_WIRED) wired <= bus.cp0_wdata[IDXW-1:0];
      if (wa == A_COUNT) begin
        count <= bus.cp0_wdata;
        div   <= '0;
      end else if (div == DIV_LAST) begin
        count <= count + 32'd1;
        div   <= '0;
      end else div <= div + 4'd1;
      ti    <= (wa == A_COMPARE) ? 1'b0 : ti | (count == compare);
      ip_hw <= bus.ext_int_in;
      if (wa == A_CAUSE) ip_sw <= bus.cp0_wdata[9:8];
      if (bus.wb_ex) begin
        exl     <= 1'b1;
        exccode <= bus.wb_excode;
        if (!exl) bd <= bus.wb_bd;
      end else if (bus.wb_eret) exl <= 1'b0;
      else if (wa == A_STATUS) exl <= bus.cp0_wdata[1];
      if (wa == A_STATUS) begin
        bev <= bus.cp0_wdata[22];
        im  <= bus.cp0_wdata[15:8];
        ie  <= bus.cp0_wdata[0];
      end
    end
  always_ff @(posedge clk) begin
    if (bus.wb_ex && !exl) epc <= bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
    else if (!bus.wb_ex && wa == A_EPC) epc <= bus.cp0_wdata;
    if (tlb_ex || addr_ex) badvaddr <= bus.wb_badvaddr;
    if (tlb_ex) vpn2 <= bus.wb_badvaddr[31:13];
    else if (bus.tlbr) vpn2 <= bus.r_vpn2;
    else if (wa == A_EHI) vpn2 <= bus.cp0_wdata[31:13];
    if (bus.tlbr) asid <= bus.r_asid;
    else if (wa == A_EHI) asid <= bus.cp0_wdata[7:0];
    if (bus.tlbr) lo0 <= {bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_g};
    else if (wa == A_LO0) lo0 <= bus.cp0_wdata[25:0];
    if (bus.tlbr) lo1 <= {bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1, bus.r_g};
    else if (wa == A_LO1) lo1 <= bus.cp0_wdata[25:0];
    if (wa == A_COMPARE) compare <= bus.cp0_wdata;
  end
`ifdef CP0_CONTEXT_EN
  logic [8:0]  ptebase;
  logic [18:0] badvpn2;
  always_ff @(posedge clk) begin
    if (wa == A_CONTEXT) ptebase <= bus.cp0_wdata[31:23];
    if (tlb_ex) badvpn2 <= bus.wb_badvaddr[31:13];
  end
  assign context_r = {ptebase, badvpn2, 4'b0};
`else
  assign context_r = '0;
`endif
  assign ip        = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign index_r   = {idx_p, {(31-IDXW){1'b0}}, idx};
  assign entryhi_r = {vpn2, 5'b0, asid};
  assign status_r  = {9'b0, bev, 6'b0, im, 6'b0, exl, ie};
  assign cause_r   = {bd, ti, 14'b0, ip, 1'b0, exccode, 2'b0};
  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      A_INDEX:   bus.cp0_rdata = index_r;
      A_RANDOM:  bus.cp0_rdata = 32'(random);
      A_LO0:     bus.cp0_rdata = {6'b0, lo0};
      A_LO1:     bus.cp0_rdata = {6'b0, lo1};
      A_CONTEXT: bus.cp0_rdata = context_r;
      A_WIRED:   bus.cp0_rdata = 32'(wired);
      A_BADV:    bus.cp0_rdata = badvaddr;
      A_COUNT:   bus.cp0_rdata = count;
      A_EHI:     bus.cp0_rdata = entryhi_r;
      A_COMPARE: bus.cp0_rdata = compare;
      A_STATUS:  bus.cp0_rdata = status_r;
      A_CAUSE:   bus.cp0_rdata = cause_r;
      A_EPC:     bus.cp0_rdata = epc;
      default:   bus.cp0_rdata = '0;
    endcase
  end
  assign bus.w_index      = bus.tlbwr ? random : idx;
  assign bus.cp0_entryhi  = entryhi_r;
  assign bus.cp0_entrylo0 = {6'b0, lo0};
  assign bus.cp0_entrylo1 = {6'b0, lo1};
  assign bus.cp0_epc      = epc;
  assign bus.cp0_status   = status_r;
  assign bus.cp0_cause    = cause_r;
  assign bus.int_req      = ie & ~exl & |(ip & im);
endmodule

// File: tb/tb_cp0_mmu.sv
// tb_cp0_mmu: directed stimulus for cp0_mmu, checked every cycle against a register-level model
module tb_cp0_mmu;
  localparam int TLBNUM = 16, DIV = 2, MAX = TLBNUM - 1;
  localparam logic [7:0] IDX = 8'h00, RND = 8'h08, LO0 = 8'h10, LO1 = 8'h18, CTX = 8'h20,
                         WIR = 8'h30, BVA = 8'h40, CNT = 8'h48, EHI = 8'h50, CMP = 8'h58,
                         STS = 8'h60, CAU = 8'h68, EPC = 8'h70;
  logic clk = 0, resetn = 0, check_en = 0;
  int n_cmp = 0, n_bad = 0;
  cp0_mmu_if #(.TLBNUM(TLBNUM)) bus ();
  cp0_mmu #(.TLBNUM(TLBNUM), .COUNT_DIV(DIV)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  // Model state: Count and Random are derived from elapsed edges rather than stepped registers
  int m_idx, m_wired, m_rk, m_ticks;
  bit m_p, m_ti, m_bd, m_bev, m_exl, m_ie, m_bva_ok, m_ctx_ok;
  logic [31:0] m_cbase, m_compare, m_epc, m_bva, m_ehi, m_lo0, m_lo1, m_ptebase;
  logic [5:0] m_iphw;
  logic [1:0] m_ipsw;
  logic [4:0] m_exc;
  logic [7:0] m_im;
  function automatic int m_rand();
    return MAX - m_rk % (MAX - m_wired + 1);
  endfunction
  function automatic logic [31:0] m_count();
    return m_cbase + 32'(m_ticks / DIV);
  endfunction
  function automatic logic [7:0] m_ip();
    return {m_iphw[5] | m_ti, m_iphw[4:0], m_ipsw};
  endfunction
  function automatic logic [31:0] m_status();
    return (32'(m_bev) << 22) | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction
  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
  endfunction
  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      IDX: return (32'(m_p) << 31) | 32'(m_idx);
      RND: return 32'(m_rand());
      LO0: return m_lo0;
      LO1: return m_lo1;
`ifdef CP0_CONTEXT_EN
      CTX: return (m_ptebase << 23) | {9'b0, m_bva[31:13], 4'b0};
`endif
      WIR: return 32'(m_wired);
      BVA: return m_bva;
      CNT: return m_count();
      EHI: return m_ehi;
      CMP: return m_compare;
      STS: return m_status();
      CAU: return m_cause();
      EPC: return m_epc;
      default: return 32'h0;
    endcase
  endfunction
  always @(posedge clk) begin
    automatic logic [7:0] wr = bus.mtc0_we ? bus.cp0_addr : 8'hff;
    automatic logic [31:0] d = bus.cp0_wdata;
    automatic bit exl_old = m_exl;
    automatic bit tlb_ex = bus.wb_ex && bus.wb_excode >= 1 && bus.wb_excode <= 3;
    automatic bit adr_ex = bus.wb_ex && (bus.wb_excode == 4 || bus.wb_excode == 5);
    if (!resetn) begin
      m_p = 0; m_idx = 0; m_wired = 0; m_rk = 0; m_cbase = 0; m_ticks = 0;
      m_bev = 1; m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
      m_iphw = 0; m_ipsw = 0; m_exc = 0;
    end else begin
      if (bus.tlbp) begin
        m_p = !bus.s1_found;
        if (bus.s1_found) m_idx = int'(bus.s1_index);
      end else if (wr == IDX) m_idx = int'(d[3:0]);
      if (wr == WIR) begin m_wired = int'(d[3:0]); m_rk = 0; end
      else m_rk++;
      m_ti = (wr == CMP) ? 0 : (m_ti || m_count() == m_compare);
      if (wr == CNT) begin m_cbase = d; m_ticks = 0; end
      else m_ticks++;
      m_iphw = bus.ext_int_in;
      if (wr == CAU) m_ipsw = d[9:8];
      if (bus.wb_ex) begin
        m_exl = 1; m_exc = bus.wb_excode;
        if (!exl_old) m_bd = bus.wb_bd;
      end else if (bus.wb_eret) m_exl = 0;
      else if (wr == STS) m_exl = d[1];
      if (wr == STS) begin m_bev = d[22]; m_im = d[15:8]; m_ie = d[0]; end
    end
    if (bus.wb_ex && !exl_old) m_epc = bus.wb_bd ? bus.wb_pc - 4 : bus.wb_pc;
    else if (!bus.wb_ex && wr == EPC) m_epc = d;
    if (tlb_ex || adr_ex) begin m_bva = bus.wb_badvaddr; m_bva_ok = 1; end
    if (tlb_ex) m_ehi[31:13] = bus.wb_badvaddr[31:13];
    else if (bus.tlbr) m_ehi[31:13] = bus.r_vpn2;
    else if (wr == EHI) m_ehi[31:13] = d[31:13];
    m_ehi[12:8] = 0;
    if (bus.tlbr) m_ehi[7:0] = bus.r_asid;
    else if (wr == EHI) m_ehi[7:0] = d[7:0];
    if (bus.tlbr) m_lo0 = {6'b0, bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_g};
    else if (wr == LO0) m_lo0 = {6'b0, d[25:0]};
    if (bus.tlbr) m_lo1 = {6'b0, bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1, bus.r_g};
    else if (wr == LO1) m_lo1 = {6'b0, d[25:0]};
    if (wr == CMP) m_compare = d;
    if (wr == CTX) begin m_ptebase = {23'b0, d[31:23]}; m_ctx_ok = 1; end
  end
  always @(negedge clk)
    if (check_en) begin
      if (!(bus.cp0_addr == BVA && !m_bva_ok) && !(bus.cp0_addr == CTX && !(m_bva_ok && m_ctx_ok)))
        chk("rdata", bus.cp0_rdata, m_read(bus.cp0_addr));
      chk("w_index", 32'(bus.w_index), 32'(bus.tlbwr ? m_rand() : m_idx));
      chk("entryhi", bus.cp0_entryhi, m_ehi);
      chk("entrylo0", bus.cp0_entrylo0, m_lo0);
      chk("entrylo1", bus.cp0_entrylo1, m_lo1);
      chk("epc", bus.cp0_epc, m_epc);
      chk("status", bus.cp0_status, m_status());
      chk("cause", bus.cp0_cause, m_cause());
      chk("int_req", 32'(bus.int_req), 32'(m_ie && !m_exl && |(m_ip() & m_im)));
    end
  task automatic tick();
    @(posedge clk);
    #1;
    bus.mtc0_we = 0; bus.wb_ex = 0; bus.wb_eret = 0;
    bus.tlbp = 0; bus.tlbr = 0; bus.tlbwi = 0; bus.tlbwr = 0;
  endtask
  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    bus.cp0_addr = a; bus.cp0_wdata = d; bus.mtc0_we = 1;
    tick();
  endtask
  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    bus.cp0_addr = a;
    #1;
    d = bus.cp0_rdata;
  endtask
  logic [31:0] v;
  int seq [4] = '{14, 13, 12, 15};
  bit got;
  initial begin
    {bus.wb_ex, bus.wb_bd, bus.wb_eret, bus.mtc0_we, bus.tlbp, bus.tlbr, bus.tlbwi, bus.tlbwr} = '0;
    bus.wb_excode = 0; bus.wb_pc = 0; bus.wb_badvaddr = 0; bus.ext_int_in = 0;
    bus.cp0_addr = 0; bus.cp0_wdata = 0; bus.s1_found = 0; bus.s1_index = 0;
    {bus.r_vpn2, bus.r_asid, bus.r_g, bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0} = '0;
    {bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1} = '0;
    // Unreset registers are given known values while reset is held
    mtc0(CMP, 32'hffff_ffff); mtc0(EHI, 0); mtc0(LO0, 0); mtc0(LO1, 0); mtc0(EPC, 0);
    check_en = 1;
    chk("rst_status", bus.cp0_status, 32'h0040_0000);
    chk("rst_cause", bus.cp0_cause, 32'h0);
    chk("rst_int_req", 32'(bus.int_req), 32'h0);
    peek(IDX, v); chk("rst_index", v, 32'h0);
    peek(CNT, v); chk("rst_count", v, 32'h0);
    peek(RND, v); chk("rst_random", v, 32'd15);
    resetn = 1;
    repeat (5) tick();
    peek(RND, v); chk("random_after5", v, 32'd10);
    repeat (10) tick();
    peek(RND, v); chk("random_zero", v, 32'd0);
    tick();
    peek(RND, v); chk("random_wrap", v, 32'd15);
    mtc0(WIR, 12);
    peek(RND, v); chk("wired12_reload", v, 32'd15);
    for (int i = 0; i < 4; i++) begin
      tick();
      peek(RND, v); chk("wired12_seq", v, 32'(seq[i]));
    end
    mtc0(WIR, MAX);
    repeat (3) tick();
    peek(RND, v); chk("wired_max_hold", v, 32'd15);
    mtc0(WIR, 0);
    mtc0(RND, 3);
    peek(8'h78, v); chk("unmapped", v, 32'h0);
    mtc0(IDX, 5);
    bus.tlbp = 1; bus.s1_found = 0; bus.s1_index = 2;
    tick();
    peek(IDX, v); chk("tlbp_miss", v, 32'h8000_0005);
    bus.tlbp = 1; bus.s1_found = 1; bus.s1_index = 7;
    tick();
    peek(IDX, v); chk("tlbp_hit", v, 32'h0000_0007);
    bus.tlbwi = 1; #1;
    chk("w_index_tlbwi", 32'(bus.w_index), 32'd7);
    bus.tlbwr = 1;
    tick();
    bus.r_vpn2 = 19'h5_5555; bus.r_asid = 8'ha5; bus.r_g = 1;
    bus.r_pfn0 = 20'h12345; bus.r_c0 = 3; bus.r_d0 = 1; bus.r_v0 = 0;
    bus.r_pfn1 = 20'habcde; bus.r_c1 = 2; bus.r_d1 = 0; bus.r_v1 = 1;
    bus.tlbr = 1;
    tick();
    chk("tlbr_entryhi", bus.cp0_entryhi, {19'h5_5555, 5'b0, 8'ha5});
    chk("tlbr_lo0", bus.cp0_entrylo0, {6'b0, 20'h12345, 3'd3, 1'b1, 1'b0, 1'b1});
    chk("tlbr_lo1", bus.cp0_entrylo1, {6'b0, 20'habcde, 3'd2, 1'b0, 1'b1, 1'b1});
    bus.wb_ex = 1; bus.wb_excode = 2; bus.wb_badvaddr = 32'h1234_5678;
    bus.wb_pc = 32'hbfc0_0100; bus.wb_bd = 1;
    tick();
    chk("ex_epc", bus.cp0_epc, 32'hbfc0_00fc);
    chk("ex_vpn2", 32'(bus.cp0_entryhi[31:13]), 32'h091a2);
    chk("ex_asid", 32'(bus.cp0_entryhi[7:0]), 32'ha5);
    chk("ex_cause", bus.cp0_cause, 32'h8000_0008);
    chk("ex_exl", 32'(bus.cp0_status[1]), 32'h1);
    peek(BVA, v); chk("ex_badvaddr", v, 32'h1234_5678);
    bus.wb_ex = 1; bus.wb_excode = 4; bus.wb_badvaddr = 32'hdead_beef;
    bus.wb_pc = 32'h8000_0000; bus.wb_bd = 0;
    tick();
    chk("nested_epc", bus.cp0_epc, 32'hbfc0_00fc);
    chk("nested_bd", 32'(bus.cp0_cause[31]), 32'h1);
    peek(BVA, v); chk("nested_badvaddr", v, 32'hdead_beef);
    bus.wb_eret = 1;
    tick();
    chk("eret_exl", 32'(bus.cp0_status[1]), 32'h0);
    bus.wb_ex = 1; bus.wb_excode = 0; bus.wb_pc = 32'h8000_1000; bus.wb_bd = 0;
    mtc0(EPC, 32'h1111_1111);
    chk("epc_ex_over_mtc0", bus.cp0_epc, 32'h8000_1000);
    bus.wb_ex = 1; bus.wb_eret = 1;
    mtc0(STS, 32'h0040_0000);
    chk("exl_ex_priority", 32'(bus.cp0_status[1]), 32'h1);
    bus.wb_eret = 1;
    tick();
    mtc0(STS, 32'h0040_8001);
    mtc0(CNT, 0);
    mtc0(CMP, 3);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = bus.cp0_cause[30];
    end
    chk("ti_set", 32'(got), 32'h1);
    chk("ti_int_req", 32'(bus.int_req), 32'h1);
    peek(CNT, v); chk("ti_count", v, 32'd3);
    mtc0(CMP, 32'hffff_ffff);
    chk("ti_clear", 32'(bus.cp0_cause[30]), 32'h0);
    chk("ti_clear_int", 32'(bus.int_req), 32'h0);
    mtc0(STS, 32'h0040_0401);
    bus.ext_int_in = 6'b000001;
    tick();
    chk("hw_int", 32'(bus.int_req), 32'h1);
    bus.ext_int_in = 0;
    tick();
    chk("hw_int_drop", 32'(bus.int_req), 32'h0);
    mtc0(STS, 32'h0040_0101);
    mtc0(CAU, 32'h0000_0100);
    chk("sw_int", 32'(bus.int_req), 32'h1);
    mtc0(STS, 32'h0040_0103);
    chk("sw_int_masked_exl", 32'(bus.int_req), 32'h0);
    repeat (3) tick();
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cp0_mmu.md
CP0_MMU -- requirements
Module: cp0_mmu

Interface
REQ-001 SHALL have parameter TLBNUM, default 16: number of TLB entries; power of two, 2..32; IDXW = log2(TLBNUM).
REQ-002 SHALL have parameter COUNT_DIV, default 2: clk cycles per Count increment; valid range 1..16.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports wb_ex, wb_bd, wb_eret, input, 1 each: exception commit, branch-delay flag, ERET commit (all from WB).
REQ-006 SHALL have ports wb_excode (input, 5), wb_pc (input, 32), wb_badvaddr (input, 32): committing exception info.
REQ-007 SHALL have port ext_int_in, input, 6: hardware interrupt lines.
REQ-008 SHALL have ports cp0_addr (input, 8, {rd,sel}), mtc0_we (input, 1), cp0_wdata (input, 32), cp0_rdata (output, 32).
REQ-009 SHALL have ports tlbp, tlbr, tlbwi, tlbwr, input, 1 each: TLB instruction commit strobes.
REQ-010 SHALL have ports s1_found (input, 1) and s1_index (input, IDXW): TLB probe result.
REQ-011 SHALL have TLB read-port inputs: r_vpn2[19], r_asid[8], r_g, r_pfn0[20], r_c0[3], r_d0, r_v0, r_pfn1[20], r_c1[3], r_d1, r_v1.
REQ-012 SHALL have port w_index, output, IDXW: TLB write index (Index on tlbwi, Random on tlbwr).
REQ-013 SHALL have outputs cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_epc, cp0_status, cp0_cause (32 each) and int_req (1).

Function
REQ-014 SHALL decode these addresses: Index 8'h00, Random 8'h08, EntryLo0 8'h10, EntryLo1 8'h18, Context 8'h20, Wired 8'h30, BadVAddr 8'h40, Count 8'h48, EntryHi 8'h50, Compare 8'h58, Status 8'h60, Cause 8'h68, EPC 8'h70.
REQ-015 SHALL make cp0_rdata combinational; unmapped addresses read 0; read-only registers (Random, BadVAddr) ignore writes.
REQ-016 SHALL apply same-cycle write priority: wb_ex > wb_eret > TLB strobes > mtc0_we; a lower-priority write to the same field is dropped.
REQ-017 SHALL decrement Random by 1 each cycle; when Random equals Wired it SHALL reload TLBNUM-1 on the next cycle instead of decrementing.
REQ-018 SHALL, on an mtc0 write to Wired, store Wired[IDXW-1:0] and set Random to TLBNUM-1 in the same update.
REQ-019 SHALL, when Wired = TLBNUM-1, hold Random at TLBNUM-1; Random SHALL never be below Wired.
REQ-020 SHALL drive w_index = Random when tlbwr is asserted, and Index[IDXW-1:0] otherwise.
REQ-021 SHALL handle tlbp as follows: hit sets Index.P=0 and Index=s1_index; miss sets P=1 and leaves the Index field unchanged.
REQ-022 SHALL, on tlbr, load EntryHi {vpn2, asid} and EntryLo0/1 {pfn, c, d, v}; the G bit of both EntryLo registers SHALL take r_g.
REQ-023 SHALL, on wb_ex with excode 1, 2 or 3 (TLB Mod/TLBL/TLBS), load BadVAddr=wb_badvaddr and EntryHi.VPN2=wb_badvaddr[31:13], with ASID unchanged.
REQ-024 SHALL, on wb_ex with excode 4 or 5, load BadVAddr only.
REQ-025 SHALL, on wb_ex with EXL=0, load EPC = wb_bd ? wb_pc-4 : wb_pc and Cause.BD = wb_bd; when EXL=1 both SHALL hold.
REQ-026 SHALL, on wb_ex, set EXL=1 and load ExcCode; wb_eret SHALL clear EXL.
REQ-027 SHALL increment Count once every COUNT_DIV cycles using an internal divider; an mtc0 write to Count SHALL load the value and zero the divider.
REQ-028 SHALL set Cause.TI whenever Count == Compare; an mtc0 write to Compare SHALL clear TI, taking precedence over a same-cycle match.
REQ-029 SHALL register Cause.IP[7:2] each cycle from ext_int_in, with IP7 ORed with TI; IP[1:0] SHALL be software-written.
REQ-030 SHALL compute int_req combinationally as IE & ~EXL & |(IP & IM).

Reset
REQ-031 SHALL, while resetn=0 at a clk edge, set: Index=0, P=0, Random=TLBNUM-1, Wired=0, Count=0, divider=0, Status={BEV=1, IM=0, EXL=0, IE=0}, Cause=0, int_req=0.
REQ-032 SHALL leave EntryHi, EntryLo0/1, EPC, BadVAddr, Compare and Context unreset, and SHALL abort any in-progress divider period.

Configuration
REQ-033 SHALL, when CP0_CONTEXT_EN is defined, implement Context at 8'h20: PTEBase [31:23] written by mtc0, BadVPN2 [22:4] loaded from wb_badvaddr[31:13] on excodes 1/2/3, bits [3:0]=0.
REQ-034 SHALL, when CP0_CONTEXT_EN is undefined, read Context as 0, ignore writes to it, and contain no Context flops.

Verification
REQ-035 SHALL cover: reset with TLBNUM=16 -> Random=15; 5 cycles later Random=10; continued cycling wraps 0 -> 15.
REQ-036 SHALL cover: mtc0 Wired=12 -> Random=15 the next cycle, then the sequence 14, 13, 12, 15, ...
REQ-037 SHALL cover: tlbp with s1_found=0 -> Index=32'h8000_0000|old index; tlbp with found=1, s1_index=7 -> Index=7.
REQ-038 SHALL cover: wb_ex, excode=2, badvaddr=32'h1234_5678, pc=32'hBFC0_0100, bd=1 -> EPC=32'hBFC0_00FC, EntryHi[31:13]=19'h091A2, BadVAddr latched.
REQ-039 SHALL cover: COUNT_DIV=2, Compare=3, IM7=1, IE=1 -> TI=1 and int_req=1 when Count reaches 3; mtc0 Compare -> TI=0 next cycle.
REQ-040 SHALL cover: mtc0 EPC together with wb_ex in the same cycle -> EPC takes the exception value.
